// File: rtl/scope_pkg.sv
// Shared types and constants for the trace dump engine: FSM state encoding,
// calibration select codes and the channel-index width helper.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_OFF,
        GET_GAIN,
        RD,
        WAIT_RD,
        XMIT,
        WAIT_TX
    } dump_state_t;

    localparam logic CAL_OFFSET = 1'b0;
    localparam logic CAL_GAIN   = 1'b1;

    // Channel index width; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_dump_engine_if.sv
// Calibration, trace RAM and transmitter signals of the dump engine.
// master = engine side, slave = the calibration store / RAM / UART side.
interface trace_dump_engine_if
    import scope_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
);
    localparam int CH_W = ch_width(NUM_CH);

    logic                     cal_req;
    logic                     cal_sel;
    logic [CH_W-1:0]          cal_chan;
    logic                     cal_valid;
    logic [DATA_W-1:0]        cal_data;
    logic                     ram_en;
    logic [ADDR_W-1:0]        ram_addr;
    logic [NUM_CH*DATA_W-1:0] ram_rdata;
    logic                     tx_trmt;
    logic [DATA_W-1:0]        tx_data;
    logic                     tx_done;

    modport master (
        output cal_req, cal_sel, cal_chan,
        input  cal_valid, cal_data,
        output ram_en, ram_addr,
        input  ram_rdata,
        output tx_trmt, tx_data,
        input  tx_done
    );

    modport slave (
        input  cal_req, cal_sel, cal_chan,
        output cal_valid, cal_data,
        input  ram_en, ram_addr,
        output ram_rdata,
        input  tx_trmt, tx_data,
        output tx_done
    );

endinterface

// File: rtl/og_correct.sv
// Offset/gain correction: saturating signed-offset add, then unsigned gain
// multiply where gain 2^(DATA_W-1) is unity. Purely combinational.
module og_correct #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] gain,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W+1:0]   sum_ext;
    logic [DATA_W-1:0]   sum_sat;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        // Two guard bits: top bit flags a negative sum, next one an overflow.
        sum_ext = {2'b00, sample} + {{2{offset[DATA_W-1]}}, offset};
        if (sum_ext[DATA_W+1]) begin
            sum_sat = '0;
        end else if (sum_ext[DATA_W]) begin
            sum_sat = '1;
        end else begin
            sum_sat = sum_ext[DATA_W-1:0];
        end
        prod   = {{DATA_W{1'b0}}, sum_sat} * {{DATA_W{1'b0}}, gain};
        result = prod[2*DATA_W-1] ? '1 : prod[2*DATA_W-2:DATA_W-1];
    end

endmodule

// File: rtl/trace_dump_engine.sv
// Dumps one channel of the circular trace RAM, oldest sample first, through
// the byte transmitter, optionally applying the channel's offset/gain calibration.
module trace_dump_engine
    import scope_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dump_req,
    input  logic [ch_width(NUM_CH)-1:0]   dump_chan,
    input  logic [ADDR_W-1:0]             trace_end,
    input  logic                          corr_bypass,
    input  logic                          abort,
    output logic                          busy,
    output logic                          dump_done,
    trace_dump_engine_if.master           bus
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = 3;

    dump_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic [ADDR_W-1:0]   end_reg;
    logic [CH_W-1:0]     chan_reg;
    logic [CH_W-1:0]     chan_next;
    logic                bypass_reg;
    logic [DATA_W-1:0]   off_reg;
    logic [DATA_W-1:0]   gain_reg;
    logic [DATA_W-1:0]   sample_reg;
    logic [DATA_W-1:0]   tx_data_reg;
    logic                tx_trmt_reg;
    logic                dump_done_reg;
    logic [CNT_W-1:0]    lat_cnt_reg;
    logic [DATA_W-1:0]   corr_result;
    logic [DATA_W-1:0]   ch_slice [NUM_CH];

    logic start, take_off, take_gain, capture, fire, advance, finish;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
        assign ch_slice[gi] = bus.ram_rdata[gi*DATA_W +: DATA_W];
    end

    // Out-of-range channel requests fall back to the last channel.
    always_comb begin
        chan_next = dump_chan;
        if (int'(dump_chan) >= NUM_CH) begin
            chan_next = CH_W'(NUM_CH - 1);
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        take_off   = 1'b0;
        take_gain  = 1'b0;
        capture    = 1'b0;
        fire       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dump_req) begin
                    start      = 1'b1;
                    state_next = corr_bypass ? RD : GET_OFF;
                end
            end
            GET_OFF: begin
                if (bus.cal_valid) begin
                    take_off   = 1'b1;
                    state_next = GET_GAIN;
                end
            end
            GET_GAIN: begin
                if (bus.cal_valid) begin
                    take_gain  = 1'b1;
                    state_next = RD;
                end
            end
            RD: state_next = WAIT_RD;
            WAIT_RD: begin
                if (lat_cnt_reg == CNT_W'(RD_LAT - 1)) begin
                    capture    = 1'b1;
                    state_next = XMIT;
                end
            end
            XMIT: begin
                fire       = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (ram_addr_reg == end_reg) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = RD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides every other event, including a completing tx_done.
        if (abort) begin
            state_next = IDLE;
            start      = 1'b0;
            take_off   = 1'b0;
            take_gain  = 1'b0;
            capture    = 1'b0;
            fire       = 1'b0;
            advance    = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr_reg  <= '0;
            end_reg       <= '0;
            chan_reg      <= '0;
            bypass_reg    <= 1'b0;
            off_reg       <= '0;
            gain_reg      <= DATA_W'(1) << (DATA_W - 1);
            sample_reg    <= '0;
            tx_data_reg   <= '0;
            tx_trmt_reg   <= 1'b0;
            dump_done_reg <= 1'b0;
            lat_cnt_reg   <= '0;
        end else begin
            tx_trmt_reg   <= fire;
            dump_done_reg <= finish;
            if (start) begin
                ram_addr_reg <= trace_end + ADDR_W'(1);
                end_reg      <= trace_end;
                chan_reg     <= chan_next;
                bypass_reg   <= corr_bypass;
            end
            if (take_off) begin
                off_reg <= bus.cal_data;
            end
            if (take_gain) begin
                gain_reg <= bus.cal_data;
            end
            if (state_reg == WAIT_RD && state_next == WAIT_RD) begin
                lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
            end else begin
                lat_cnt_reg <= '0;
            end
            if (capture) begin
                sample_reg <= ch_slice[chan_reg];
            end
            if (fire) begin
                tx_data_reg <= bypass_reg ? sample_reg : corr_result;
            end
            if (advance) begin
                ram_addr_reg <= ram_addr_reg + ADDR_W'(1);
            end
        end
    end

    og_correct #(.DATA_W(DATA_W)) u_og_correct (
        .sample (sample_reg),
        .offset (off_reg),
        .gain   (gain_reg),
        .result (corr_result)
    );

    assign bus.cal_req  = (state_reg == GET_OFF) || (state_reg == GET_GAIN);
    assign bus.cal_sel  = (state_reg == GET_GAIN) ? CAL_GAIN : CAL_OFFSET;
    assign bus.cal_chan = chan_reg;
    assign bus.ram_en   = (state_reg == RD);
    assign bus.ram_addr = ram_addr_reg;
    assign bus.tx_trmt  = tx_trmt_reg;
    assign bus.tx_data  = tx_data_reg;
    assign busy         = (state_reg != IDLE);
    assign dump_done    = dump_done_reg;

endmodule

// File: tb/tb_trace_dump_engine.sv
// Directed bench for trace_dump_engine: RAM, calibration and transmitter models,
// a per-byte monitor with an independent correction model, and directed dumps.
module tb_trace_dump_engine;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 9;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 512;

    logic       clk = 1'b0;
    logic       rst_n, dump_req, corr_bypass, abort;
    logic [1:0] dump_chan;
    logic [8:0] trace_end;
    logic       busy, dump_done;

    always #5 clk = ~clk;

    trace_dump_engine_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    trace_dump_engine #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dump_req    (dump_req),
        .dump_chan   (dump_chan),
        .trace_end   (trace_end),
        .corr_bypass (corr_bypass),
        .abort       (abort),
        .busy        (busy),
        .dump_done   (dump_done),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Test configuration (written only by the main process)
    int         cfg_chan, eff_chan, abort_at;
    logic [7:0] cfg_off, cfg_gain;
    logic       cfg_byp, cfg_stab;

    // Trace RAM: three-stage read pipeline
    logic [23:0] mem [DEPTH];
    logic [23:0] p0, p1, p2;
    always @(posedge clk) begin
        if (bus.ram_en) p0 <= mem[bus.ram_addr];
        p1 <= p0;
        p2 <= p1;
    end
    assign bus.ram_rdata = p2;

    function automatic logic [7:0] sample_of(input logic [8:0] a);
        logic [23:0] w;
        w = mem[a];
        return w[eff_chan*8 +: 8];
    endfunction

    function automatic logic [7:0] model(input logic [7:0] s, input logic [7:0] o,
                                         input logic [7:0] g, input logic byp);
        int sum, p;
        if (byp) return s;
        sum = int'(s) + int'($signed(o));
        if (sum < 0) sum = 0;
        if (sum > 255) sum = 255;
        p = (sum * int'(g)) / 128;
        if (p > 255) p = 255;
        return p[7:0];
    endfunction

    // Calibration responder: answers after three request cycles
    int cal_wait;
    initial begin
        bus.cal_valid = 1'b0;
        bus.cal_data  = '0;
        cal_wait      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.cal_req) begin
                bus.cal_valid = 1'b0;
                cal_wait      = 0;
            end else if (cal_wait == 2) begin
                bus.cal_valid = 1'b1;
                bus.cal_data  = bus.cal_sel ? cfg_gain : cfg_off;
                cal_wait      = 0;
            end else begin
                bus.cal_valid = 1'b0;
                cal_wait++;
            end
        end
    end

    // Transmitter: tx_done two cycles after the strobe; abort rides on a chosen done
    int tx_wait, n_done;
    initial begin
        bus.tx_done = 1'b0;
        abort       = 1'b0;
        tx_wait     = 0;
        n_done      = 0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            abort       = 1'b0;
            if (!rst_n) begin
                tx_wait = 0;
            end else if (tx_wait > 0) begin
                tx_wait--;
                if (tx_wait == 0) begin
                    bus.tx_done = 1'b1;
                    n_done++;
                    if (n_done == abort_at) abort = 1'b1;
                end
            end else if (bus.tx_trmt) begin
                tx_wait = 2;
            end
        end
    end

    // Monitor
    int         n_tx, n_en, n_dd, n_oc, n_gc, cal_chan_err, stab_err, n_orphan;
    logic [8:0] exp_addr, first_addr, last_addr, a_pop;
    logic [7:0] first_tx, prev_tx;
    logic       seen_en, seen_tx;
    logic [8:0] addr_q [$];
    initial begin
        n_tx = 0; n_en = 0; n_dd = 0; n_oc = 0; n_gc = 0;
        cal_chan_err = 0; stab_err = 0; n_orphan = 0;
        exp_addr = '0; first_addr = '0; last_addr = '0; first_tx = '0; prev_tx = '0;
        seen_en = 1'b0; seen_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                addr_q.delete();
            end else begin
                if (dump_req && !busy) begin
                    addr_q.delete();
                    exp_addr = trace_end + 9'd1;
                    seen_en  = 1'b0;
                    seen_tx  = 1'b0;
                end
                if (bus.ram_en) begin
                    check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
                    if (!seen_en) first_addr = bus.ram_addr;
                    seen_en   = 1'b1;
                    last_addr = bus.ram_addr;
                    addr_q.push_back(bus.ram_addr);
                    exp_addr  = exp_addr + 9'd1;
                    n_en++;
                end
                if (bus.tx_trmt) begin
                    n_tx++;
                    if (!seen_tx) first_tx = bus.tx_data;
                    seen_tx = 1'b1;
                    if (addr_q.size() == 0) begin
                        n_orphan++;
                    end else begin
                        a_pop = addr_q.pop_front();
                        check("tx_byte", 32'(bus.tx_data),
                              32'(model(sample_of(a_pop), cfg_off, cfg_gain, cfg_byp)));
                    end
                end
                if (dump_done) n_dd++;
                if (bus.cal_req) begin
                    if (bus.cal_sel) n_gc++;
                    else n_oc++;
                    if (int'(bus.cal_chan) != eff_chan) cal_chan_err++;
                end
                if (cfg_stab && !bus.tx_trmt && bus.tx_data != prev_tx) stab_err++;
            end
            prev_tx = bus.tx_data;
        end
    end

    int s_tx, s_en, s_dd, s_oc, s_gc;

    task automatic start_dump(input int ch, input logic [8:0] te, input logic byp,
                              input logic [7:0] off, input logic [7:0] gn, input int abort_k);
        @(posedge clk); #1;
        cfg_chan = ch;
        eff_chan = (ch >= NUM_CH) ? NUM_CH - 1 : ch;
        cfg_off  = off;
        cfg_gain = gn;
        cfg_byp  = byp;
        abort_at = (abort_k > 0) ? n_done + abort_k : -1;
        s_tx = n_tx; s_en = n_en; s_dd = n_dd; s_oc = n_oc; s_gc = n_gc;
        $display("dump: chan=%0d trace_end=0x%03h bypass=%0d off=0x%02h gain=0x%02h abort_after=%0d",
                 ch, te, byp, off, gn, abort_k);
        dump_chan   = 2'(ch);
        trace_end   = te;
        corr_bypass = byp;
        dump_req    = 1'b1;
        @(posedge clk); #1;
        dump_req    = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (busy && i < limit) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_dump_done", 32'(dump_done),    32'd0);
        check("rst_ram_en",    32'(bus.ram_en),   32'd0);
        check("rst_tx_trmt",   32'(bus.tx_trmt),  32'd0);
        check("rst_cal_req",   32'(bus.cal_req),  32'd0);
        check("rst_cal_sel",   32'(bus.cal_sel),  32'd0);
        check("rst_ram_addr",  32'(bus.ram_addr), 32'd0);
        check("rst_tx_data",   32'(bus.tx_data),  32'd0);
        check("rst_cal_chan",  32'(bus.cal_chan), 32'd0);
    endtask

    initial begin
        int i;
        rst_n = 1'b0; dump_req = 1'b0; dump_chan = '0; trace_end = '0; corr_bypass = 1'b0;
        cfg_chan = 0; eff_chan = 0; cfg_off = '0; cfg_gain = 8'h80; cfg_byp = 1'b0;
        cfg_stab = 1'b0; abort_at = -1;
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = {8'(a * 7 + 3), 8'(a ^ 421), 8'(a)};
        end
        mem[9'h000][7:0]   = 8'h40;
        mem[9'h100][15:8]  = 8'hF0;
        mem[9'h021][23:16] = 8'h20;
        mem[9'h051][7:0]   = 8'h80;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n    = 1'b1;
        cfg_stab = 1'b1;

        // Full corrected dump from a wrapped end pointer, with an ignored request mid-dump
        start_dump(0, 9'h1FF, 1'b0, 8'h10, 8'h80, 0);
        repeat (200) @(posedge clk);
        #1;
        dump_chan = 2'd1; trace_end = 9'h050; corr_bypass = 1'b1; dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0; dump_chan = 2'd0; trace_end = 9'h1FF; corr_bypass = 1'b0;
        wait_idle(10000);
        check("full_tx_count",   32'(n_tx - s_tx), 32'd512);
        check("full_en_count",   32'(n_en - s_en), 32'd512);
        check("full_done_count", 32'(n_dd - s_dd), 32'd1);
        check("full_first_addr", 32'(first_addr),  32'h000);
        check("full_last_addr",  32'(last_addr),   32'h1FF);
        check("full_first_byte", 32'(first_tx),    32'h50);
        check("full_off_cycles", 32'(n_oc - s_oc), 32'd3);
        check("full_gain_cycles",32'(n_gc - s_gc), 32'd3);

        // Saturation cases, three bytes each then abort
        start_dump(1, 9'h0FF, 1'b0, 8'h7F, 8'h80, 3);
        wait_idle(500);
        check("sat_hi_byte",  32'(first_tx),       32'hFF);
        check("sat_hi_count", 32'(n_tx - s_tx),    32'd3);
        check("sat_hi_done",  32'(n_dd - s_dd),    32'd0);

        start_dump(3, 9'h020, 1'b0, 8'h80, 8'h80, 3);
        wait_idle(500);
        check("sat_lo_byte",  32'(first_tx),       32'h00);
        check("sat_lo_first", 32'(first_addr),     32'h021);

        start_dump(0, 9'h050, 1'b0, 8'h00, 8'hFF, 3);
        wait_idle(500);
        check("sat_gain_byte", 32'(first_tx),      32'hFF);

        // Bypass dump of channel 2
        start_dump(2, 9'h0A0, 1'b1, 8'h33, 8'h44, 0);
        wait_idle(10000);
        check("byp_cal_cycles",  32'(n_oc - s_oc + n_gc - s_gc), 32'd0);
        check("byp_tx_count",    32'(n_tx - s_tx), 32'd512);
        check("byp_done_count",  32'(n_dd - s_dd), 32'd1);
        check("byp_first_addr",  32'(first_addr),  32'h0A1);
        check("byp_last_addr",   32'(last_addr),   32'h0A0);

        // Abort on the fifth tx_done, then restart
        start_dump(1, 9'h1FD, 1'b0, 8'h05, 8'h90, 5);
        wait_idle(500);
        check("abort_tx_count",  32'(n_tx - s_tx), 32'd5);
        check("abort_no_done",   32'(n_dd - s_dd), 32'd0);
        check("abort_last_addr", 32'(last_addr),   32'h002);
        start_dump(1, 9'h1FD, 1'b0, 8'h05, 8'h90, 2);
        wait_idle(500);
        check("restart_first_addr", 32'(first_addr),  32'h1FE);
        check("restart_tx_count",   32'(n_tx - s_tx), 32'd2);

        // Reset while waiting on the RAM read
        start_dump(2, 9'h010, 1'b1, 8'h00, 8'h80, 0);
        i = 0;
        while (!bus.ram_en && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("saw_ram_en", 32'(bus.ram_en), 32'd1);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        cfg_stab = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        check("rst_mid_no_tx", 32'(n_tx - s_tx), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cfg_stab = 1'b1;

        start_dump(1, 9'h133, 1'b0, 8'hF0, 8'hA0, 0);
        wait_idle(10000);
        check("post_rst_tx_count",   32'(n_tx - s_tx), 32'd512);
        check("post_rst_done_count", 32'(n_dd - s_dd), 32'd1);
        check("post_rst_first_addr", 32'(first_addr),  32'h134);

        check("cal_chan_errors", 32'(cal_chan_err), 32'd0);
        check("tx_data_stable",  32'(stab_err),     32'd0);
        check("orphan_strobes",  32'(n_orphan),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_dump_engine.md
TRACE_DUMP_ENGINE -- requirements
Module: trace_dump_engine

Interface
REQ-001 Parameter NUM_CH, default 3, meaning: number of capture channels.
REQ-002 Parameter DATA_W, default 8, meaning: sample, offset, gain and tx byte width.
REQ-003 Parameter ADDR_W, default 9, meaning: trace RAM address width; depth is 2^ADDR_W.
REQ-004 Parameter RD_LAT, default 1, meaning: RAM read latency in clocks, 1..4.
REQ-005 Port clk, input, 1, meaning: single system clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1, meaning: synchronous active-low reset.
REQ-007 Port dump_req, input, 1, meaning: one-cycle pulse that starts a dump.
REQ-008 Port dump_chan, input, CH_W=max(1,$clog2(NUM_CH)), meaning: channel to dump.
REQ-009 Port trace_end, input, ADDR_W, meaning: address of the newest captured sample.
REQ-010 Port corr_bypass, input, 1, meaning: 1 sends raw samples and skips the calibration fetch.
REQ-011 Port abort, input, 1, meaning: terminates any dump in progress.
REQ-012 Port cal_req, output, 1, meaning: calibration fetch request.
REQ-013 Port cal_sel, output, 1, meaning: 0 requests offset, 1 requests gain.
REQ-014 Port cal_chan, output, CH_W, meaning: channel whose calibration is requested.
REQ-015 Port cal_valid, input, 1, meaning: cal_data is valid this cycle.
REQ-016 Port cal_data, input, DATA_W, meaning: calibration value returned.
REQ-017 Port ram_en, output, 1, meaning: RAM read enable.
REQ-018 Port ram_addr, output, ADDR_W, meaning: RAM read address.
REQ-019 Port ram_rdata, input, NUM_CH*DATA_W, meaning: all channels packed; channel k is bits [k*DATA_W +: DATA_W].
REQ-020 Port tx_trmt, output, 1, meaning: one-cycle transmit strobe.
REQ-021 Port tx_data, output, DATA_W, meaning: byte to transmit.
REQ-022 Port tx_done, input, 1, meaning: transmitter finished the current byte.
REQ-023 Port busy, output, 1, meaning: high in every state except IDLE.
REQ-024 Port dump_done, output, 1, meaning: one-cycle pulse when a dump completes normally.

Function
REQ-025 The FSM SHALL have states IDLE, GET_OFF, GET_GAIN, RD, WAIT_RD, XMIT, WAIT_TX.
REQ-026 In IDLE, dump_req SHALL latch dump_chan and trace_end, set ram_addr=trace_end+1 mod 2^ADDR_W, and go to GET_OFF, or to RD if corr_bypass=1.
REQ-027 A dump_chan value >= NUM_CH SHALL select channel NUM_CH-1.
REQ-028 In GET_OFF and GET_GAIN, cal_req SHALL be held high with cal_sel=0 and cal_sel=1 respectively; cal_valid SHALL store cal_data and advance the FSM (GET_OFF->GET_GAIN, GET_GAIN->RD).
REQ-029 cal_valid SHALL be ignored while cal_req is low.
REQ-030 RD SHALL assert ram_en for exactly one cycle and then enter WAIT_RD.
REQ-031 WAIT_RD SHALL count RD_LAT cycles, then register the selected channel slice of ram_rdata and enter XMIT.
REQ-032 Correction: sum = sample + sign-extended offset, saturated to [0, 2^DATA_W-1].
REQ-033 Correction: prod = sum*gain, unsigned, 2*DATA_W bits; result = 2^DATA_W-1 if prod[2*DATA_W-1]=1, else prod[2*DATA_W-2:DATA_W-1]. Gain 2^(DATA_W-1) is unity.
REQ-034 With corr_bypass latched at 1, result SHALL equal the sample.
REQ-035 XMIT SHALL register the result into tx_data, pulse tx_trmt for one cycle, and enter WAIT_TX; tx_data SHALL stay stable until the next XMIT.
REQ-036 In WAIT_TX, tx_done SHALL end the dump if ram_addr==latched trace_end: pulse dump_done and go to IDLE.
REQ-037 Otherwise in WAIT_TX, tx_done SHALL increment ram_addr mod 2^ADDR_W and go to RD.
REQ-038 Each dump SHALL transmit exactly 2^ADDR_W bytes, oldest first.
REQ-039 dump_req while busy SHALL be ignored.
REQ-040 abort SHALL force IDLE on the next edge with no dump_done pulse, and SHALL win over a simultaneous tx_done or cal_valid.

Reset
REQ-041 When rst_n=0 at a clock edge, the block SHALL enter IDLE with ram_en, tx_trmt, cal_req, cal_sel, busy and dump_done=0, and ram_addr, tx_data, cal_chan=0.
REQ-042 The offset register SHALL reset to 0 and the gain register to 2^(DATA_W-1).
REQ-043 Reset SHALL take effect mid-dump exactly as in IDLE.

Structure
REQ-044 Package scope_pkg SHALL hold the dump_state_t enum and the CAL_OFFSET/CAL_GAIN constants.
REQ-045 The correction datapath SHALL be a separate sub-module named og_correct, parametrised by DATA_W, and purely combinational.

Verification
REQ-046 Offset 0x10, gain 0x80, sample 0x40 -> tx_data=0x50.
REQ-047 Saturation: offset 0x7F, sample 0xF0 -> 0xFF; offset 0x80, sample 0x20 -> 0x00; offset 0, gain 0xFF, sample 0x80 -> 0xFF.
REQ-048 trace_end=0x1FF -> first ram_addr 0x000, last 0x1FF, 512 tx_trmt pulses, then one dump_done.
REQ-049 corr_bypass=1, dump_chan=2 -> no cal_req; tx_data equals ram_rdata[23:16] for each address.
REQ-050 abort asserted in the same cycle as the 5th tx_done -> IDLE, no dump_done; a new dump_req restarts at trace_end+1.
REQ-051 rst_n=0 during WAIT_RD with RD_LAT=3 -> all REQ-041 values on the next edge; a subsequent dump behaves normally.
